// File: rtl/store_display_sched_if.sv
// Store-snoop bus plus 7-segment display outputs shared between the core side and the display scheduler.
interface store_display_sched_if #(
  parameter int DEPTH = 4
);
  logic                         mem_write;
  logic [31:0]                  data_adr;
  logic [31:0]                  write_data;
  logic                         pause;
  logic [6:0]                   hex00;
  logic [6:0]                   hex01;
  logic [6:0]                   hex10;
  logic [6:0]                   hex11;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic                         busy;
  logic                         overflow;

  modport master (
    output mem_write, data_adr, write_data, pause,
    input  hex00, hex01, hex10, hex11, fifo_count, busy, overflow
  );

  modport slave (
    input  mem_write, data_adr, write_data, pause,
    output hex00, hex01, hex10, hex11, fifo_count, busy, overflow
  );
endinterface

// File: rtl/store_display_sched.sv
// Queues snooped stores and shows each {addr,data} byte pair on four 7-seg digits for HOLD_CYCLES; 1-cycle store-to-display.
// A full FIFO drops new stores (sticky overflow) unless a pop frees a slot on the same edge; pause stalls timer and pops.
module store_display_sched #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  store_display_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(HOLD_CYCLES + 1);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic {IDLE, HOLD} state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;
  state_t          state;
  logic            busy_q;
  logic            ovf_q;
  logic [6:0]      h00, h01, h10, h11;
  logic            pop;
  logic            push;
  logic            unused_hi;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign unused_hi = ^{bus.data_adr[31:8], bus.write_data[31:8]};
  assign head      = mem[rd_ptr];

  always_comb begin
    pop  = !bus.pause && (count != '0) && ((state == IDLE) || (timer == '0));
    push = bus.mem_write && ((count < CW'(DEPTH)) || pop);
  end

  // Storage is not reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= '{addr: bus.data_adr[7:0], data: bus.write_data[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (bus.mem_write && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= '0;
      busy_q <= 1'b0;
      h00    <= 7'h3F;
      h01    <= 7'h3F;
      h10    <= 7'h3F;
      h11    <= 7'h3F;
    end else if (pop) begin
      state  <= HOLD;
      busy_q <= 1'b1;
      timer  <= TW'(HOLD_CYCLES - 1);
      h00    <= seg(head.data[3:0]);
      h01    <= seg(head.data[7:4]);
      h10    <= seg(head.addr[3:0]);
      h11    <= seg(head.addr[7:4]);
    end else if (state == HOLD && !bus.pause) begin
      if (timer != '0) begin
        timer <= timer - TW'(1);
      end else begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.hex00      = h00;
  assign bus.hex01      = h01;
  assign bus.hex10      = h10;
  assign bus.hex11      = h11;
  assign bus.fifo_count = count;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_store_display_sched.sv
// Bench for store_display_sched: decode table, directed corner sequences, and random traffic against a queue-based model.
module tb_store_display_sched;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  store_display_sched_if #(.DEPTH(DEPTH)) bus ();

  store_display_sched #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  // Model: a queue of pending entries, the entry on display and its remaining display cycles.
  ent_t       q[$];
  logic [6:0] m_hex [4];
  bit         m_act;
  int         m_rem;
  bit         m_ovf;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_update(input bit rst, input bit mw, input bit pz, input logic [7:0] a, input logic [7:0] d);
    bit   take;
    ent_t e;
    if (!rst) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_hex[i] = 7'h3F;
      m_act = 0;
      m_rem = 0;
      m_ovf = 0;
    end else begin
      take = !pz && (q.size() > 0) && (!m_act || m_rem == 1);
      if (take) begin
        e = q.pop_front();
        m_hex[0] = SEG[e.d[3:0]];
        m_hex[1] = SEG[e.d[7:4]];
        m_hex[2] = SEG[e.a[3:0]];
        m_hex[3] = SEG[e.a[7:4]];
        m_act = 1;
        m_rem = HOLD;
      end else if (m_act && !pz) begin
        if (m_rem == 1) m_act = 0;
        else m_rem--;
      end
      if (mw) begin
        if (q.size() < DEPTH) q.push_back('{a: a, d: d});
        else m_ovf = 1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit mw, input bit pz, input logic [31:0] adr, input logic [31:0] dat);
    reset          = rst;
    bus.mem_write  = mw;
    bus.pause      = pz;
    bus.data_adr   = adr;
    bus.write_data = dat;
    @(posedge clk);
    m_update(rst, mw, pz, adr[7:0], dat[7:0]);
    #1;
    check("model",
          {bus.hex11, bus.hex10, bus.hex01, bus.hex00, bus.fifo_count, bus.busy, bus.overflow},
          {m_hex[3], m_hex[2], m_hex[1], m_hex[0], 3'(q.size()), m_act, m_ovf});
  endtask

  task automatic idle();
    step(1, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    step(1, 1, 0, adr, dat);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [27:0] exp;
  } vec_t;

  vec_t       vecs [5];
  int         n;
  logic [6:0] seen[$];
  logic [6:0] last;
  logic [6:0] burst_exp [6];

  initial begin
    reset = 1'b0;
    bus.mem_write = 1'b0;
    bus.pause = 1'b0;
    bus.data_adr = '0;
    bus.write_data = '0;

    vecs[0] = '{32'hDEAD_0010, 32'hBEEF_0032, {7'h79, 7'h40, 7'h30, 7'h24}};
    vecs[1] = '{32'h0000_0054, 32'hFFFF_FF76, {7'h12, 7'h19, 7'h78, 7'h02}};
    vecs[2] = '{32'h1234_5698, 32'h0000_00BA, {7'h10, 7'h00, 7'h03, 7'h08}};
    vecs[3] = '{32'h0000_00DC, 32'h0000_00FE, {7'h21, 7'h46, 7'h0E, 7'h06}};
    vecs[4] = '{32'h0000_001C, 32'h0000_00A7, {7'h79, 7'h46, 7'h08, 7'h78}};
    burst_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

    do_reset();
    check("reset_state", {bus.hex11, bus.hex10, bus.hex01, bus.hex00, bus.fifo_count, bus.busy, bus.overflow},
          {7'h3F, 7'h3F, 7'h3F, 7'h3F, 3'd0, 1'b0, 1'b0});

    for (int i = 0; i < 5; i++) begin
      repeat (6) idle();
      store(vecs[i].adr, vecs[i].dat);
      idle();
      check("decode", {bus.hex11, bus.hex10, bus.hex01, bus.hex00}, vecs[i].exp);
    end

    // Single store: busy lasts exactly HOLD cycles, display persists into IDLE.
    repeat (6) idle();
    store(32'h1C, 32'hA7);
    idle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      n++;
      idle();
    end
    check("single_busy_cycles", n, HOLD);
    check("single_display_kept", {bus.hex11, bus.hex10, bus.hex01, bus.hex00}, {7'h79, 7'h46, 7'h08, 7'h78});

    // Burst of 7: the 6th push meets a pop while full, the 7th is dropped.
    do_reset();
    last = 7'h3F;
    for (int k = 0; k < 7; k++) begin
      store(32'h30 + k, k);
      if (bus.hex00 !== last) begin seen.push_back(bus.hex00); last = bus.hex00; end
      if (k == 5) check("full_push_pop", {bus.fifo_count, bus.overflow}, {3'd4, 1'b0});
    end
    check("burst_overflow", {bus.fifo_count, bus.overflow}, {3'd4, 1'b1});
    for (int i = 0; i < 40; i++) begin
      idle();
      if (bus.hex00 !== last) begin seen.push_back(bus.hex00); last = bus.hex00; end
    end
    check("burst_len", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) check("burst_order", seen[i], burst_exp[i]);

    // Pause mid-HOLD stretches display by the paused cycles.
    do_reset();
    store(32'h42, 32'h17);
    idle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      n++;
      step(1, 0, (i >= 1 && i <= 3), 32'h0, 32'h0);
    end
    check("pause_hold_cycles", n, HOLD + 3);

    // Pause in IDLE blocks pops.
    do_reset();
    step(1, 1, 1, 32'h11, 32'h22);
    step(1, 1, 1, 32'h33, 32'h44);
    step(1, 0, 1, 32'h0, 32'h0);
    step(1, 0, 1, 32'h0, 32'h0);
    check("idle_pause_no_pop", {bus.busy, bus.fifo_count}, {1'b0, 3'd2});
    idle();
    check("idle_pause_release", {bus.busy, bus.fifo_count, bus.hex00}, {1'b1, 3'd1, 7'h24});

    // Reset mid-HOLD discards queue, then a fresh store displays normally.
    do_reset();
    for (int k = 0; k < 4; k++) store(32'h50 + k, 32'h60 + k);
    check("pre_reset_queue", {bus.busy, bus.fifo_count}, {1'b1, 3'd3});
    step(0, 0, 0, 32'h0, 32'h0);
    check("reset_mid_hold", {bus.hex11, bus.hex10, bus.hex01, bus.hex00, bus.fifo_count, bus.busy},
          {7'h3F, 7'h3F, 7'h3F, 7'h3F, 3'd0, 1'b0});
    idle();
    store(32'h2B, 32'h9F);
    idle();
    check("after_reset_store", {bus.hex11, bus.hex10, bus.hex01, bus.hex00}, {7'h24, 7'h03, 7'h10, 7'h0E});

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 6) == 0),
           $urandom(), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
